// File: rtl/pong_frame_scheduler.sv
// Pong frame sequencer: tick prescaler, frame counter and a paddle -> ball -> collision launch FSM.
// Optional macro SCHED_SINGLE_STEP_EN adds a step input that launches one frame while stopped.
module pong_frame_scheduler #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 10_000,
  parameter int FRAME_TICKS = 100,
  parameter int TIMEOUT     = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [1:0] speed,
  input  logic       clr_err,
`ifdef SCHED_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic       tick,
  output logic       frame_strobe,
  output logic       paddle_start,
  input  logic       paddle_done,
  output logic       ball_start,
  input  logic       ball_done,
  output logic       coll_start,
  input  logic       coll_done,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err,
  output logic [1:0] state_dbg
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int FW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int WW  = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PADDLE = 2'd1,
    S_BALL   = 2'd2,
    S_COLL   = 2'd3
  } state_t;

  logic [DW-1:0] div_cnt;
  logic [FW-1:0] frame_cnt;
  state_t        state_q, state_d;
  logic          first_q, first_d;
  logic [1:0]    pass_q, pass_d;
  logic [1:0]    speed_q, speed_d;
  logic [WW-1:0] wait_q;
  logic          timeout_set;
  logic          eng_done;
  logic          launch;
  logic          keep_going;

  assign tick         = (div_cnt == DIV_LAST);
  assign frame_strobe = tick && (frame_cnt == FRAME_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      frame_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
    end
  end

`ifdef SCHED_SINGLE_STEP_EN
  logic step_launch;
  logic step_mode_q;
  assign step_launch = step && !run;
  assign launch      = (frame_strobe && run) || step_launch;
  // A stepped frame runs to completion even though run is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    step_mode_q <= 1'b0;
    else if (state_q == S_IDLE) step_mode_q <= step_launch;
  end
  assign keep_going = run || step_mode_q;
`else
  assign launch     = frame_strobe && run;
  assign keep_going = run;
`endif

  // Handshake: *_start is high only in the first cycle of its state; *_done is
  // sampled from the following cycle on, and one sampled high ends the state.
  assign eng_done = ((state_q == S_PADDLE) && paddle_done) ||
                    ((state_q == S_BALL)   && ball_done)   ||
                    ((state_q == S_COLL)   && coll_done);

  always_comb begin
    state_d     = state_q;
    first_d     = 1'b0;
    pass_d      = pass_q;
    speed_d     = speed_q;
    timeout_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_PADDLE;
          first_d = 1'b1;
          pass_d  = '0;
          speed_d = speed;
        end
      end
      S_PADDLE, S_BALL, S_COLL: begin
        if (!first_q && eng_done) begin
          if (!keep_going)                   state_d = S_IDLE;
          else if (state_q == S_PADDLE)      state_d = S_BALL;
          else if (state_q == S_BALL)        state_d = S_COLL;
          else if (pass_q < speed_q)         state_d = S_BALL;
          else                               state_d = S_IDLE;
          if (state_q == S_COLL) pass_d = pass_q + 2'd1;
          first_d = (state_d != S_IDLE);
        end else if (wait_q == WAIT_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      pass_q  <= '0;
      speed_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      speed_q <= speed_d;
      wait_q  <= (first_d || state_q == S_IDLE) ? '0 : wait_q + 1'b1;
    end
  end

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (frame_strobe && busy) overrun <= 1'b1;
      else if (clr_err)         overrun <= 1'b0;
      if (timeout_set)          timeout_err <= 1'b1;
      else if (clr_err)         timeout_err <= 1'b0;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign paddle_start = first_q && (state_q == S_PADDLE);
  assign ball_start   = first_q && (state_q == S_BALL);
  assign coll_start   = first_q && (state_q == S_COLL);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Bench for pong_frame_scheduler (DIV=10, FRAME_TICKS=4, TIMEOUT=20): engine responders,
// start-event log, and per-scenario tasks checking against a cycle-level frame model.
`timescale 1ns/1ps
module tb_pong_frame_scheduler;
  localparam int FRAME_CYC = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       clr_err = 1'b0;
  logic [1:0] speed = 2'd0;
`ifdef SCHED_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif
  logic       paddle_done = 1'b0, ball_done = 1'b0, coll_done = 1'b0;
  logic       tick, frame_strobe, paddle_start, ball_start, coll_start;
  logic       busy, overrun, timeout_err;
  logic [1:0] state_dbg;

  int cyc;
  int checks = 0;
  int errors = 0;
  int p_lat = 2, b_lat = 2, c_lat = 2;
  int p_due = -1, b_due = -1, c_due = -1;
  bit p_level = 1'b0;
  int busy_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];

  pong_frame_scheduler #(
    .CLK_HZ(100), .TICK_HZ(10), .FRAME_TICKS(4), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .speed(speed), .clr_err(clr_err),
`ifdef SCHED_SINGLE_STEP_EN
    .step(step),
`endif
    .tick(tick), .frame_strobe(frame_strobe),
    .paddle_start(paddle_start), .paddle_done(paddle_done),
    .ball_start(ball_start), .ball_done(ball_done),
    .coll_start(coll_start), .coll_done(coll_done),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle index ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input int eng, input int c);
    return 32'(eng * 16777216 + c);
  endfunction

  // ---------------- engine responders and start monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      p_due = -1; b_due = -1; c_due = -1;
      paddle_done = 1'b0; ball_done = 1'b0; coll_done = 1'b0;
    end else begin
      paddle_done = p_level || (cyc == p_due);
      ball_done   = (cyc == b_due);
      coll_done   = (cyc == c_due);
      if (paddle_start) begin p_due = cyc + p_lat; log_q.push_back(enc(0, cyc)); end
      if (ball_start)   begin b_due = cyc + b_lat; log_q.push_back(enc(1, cyc)); end
      if (coll_start)   begin c_due = cyc + c_lat; log_q.push_back(enc(2, cyc)); end
      if (busy) busy_cnt++;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic int next_strobe();
    int c;
    c = cyc + 2;
    while (c % FRAME_CYC != FRAME_CYC - 1) c++;
    return c;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({tick, frame_strobe, paddle_start, ball_start, coll_start, busy, overrun, timeout_err, state_dbg} !== 10'd0) begin
      errors++;
      $display("FAIL reset_hold outputs got %b exp 0",
        {tick, frame_strobe, paddle_start, ball_start, coll_start, busy, overrun, timeout_err, state_dbg});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({tick, frame_strobe, paddle_start, ball_start, coll_start, busy, overrun, timeout_err} !== 8'd0) begin
      errors++;
      $display("FAIL reset_release outputs got %b exp 0",
        {tick, frame_strobe, paddle_start, ball_start, coll_start, busy, overrun, timeout_err});
    end
  endtask

  task automatic test_prescaler();
    for (int c = 1; c <= 85; c++) begin
      wait_cyc(c);
      checks++;
      if (tick !== (c % 10 == 9)) begin
        errors++;
        $display("FAIL tick cycle %0d got %b exp %b", c, tick, (c % 10 == 9));
      end
      checks++;
      if (frame_strobe !== (c % 40 == 39)) begin
        errors++;
        $display("FAIL frame_strobe cycle %0d got %b exp %b", c, frame_strobe, (c % 40 == 39));
      end
      checks++;
      if ({busy, paddle_start, ball_start, coll_start} !== 4'd0) begin
        errors++;
        $display("FAIL idle_run0 cycle %0d got %b exp 0000", c, {busy, paddle_start, ball_start, coll_start});
      end
    end
  endtask

  // One run-launched frame; model: paddle one clk after the strobe, each next start
  // one clk after the done, (speed+1) ball/coll pairs, busy until the last done.
  task automatic test_frame(input int spd, input int pl, input int bl, input int cl, input string name);
    int c0, t, last_end, base, bbase;
    last_end = 0;
    c0 = next_strobe();
    wait_cyc(c0 - 1);
    p_lat = pl; b_lat = bl; c_lat = cl;
    speed = 2'(spd);
    run = 1'b1;
    base = log_q.size();
    bbase = busy_cnt;
    exp_q.delete();
    t = c0 + 1;
    exp_q.push_back(enc(0, t));
    t += pl + 1;
    for (int k = 0; k <= spd; k++) begin
      exp_q.push_back(enc(1, t));
      t += bl + 1;
      exp_q.push_back(enc(2, t));
      last_end = t + cl;
      t += cl + 1;
    end
    wait_cyc(c0 + 1);
    speed = 2'($urandom_range(0, 3));
    wait_cyc(last_end + 1);
    run = 1'b0;
    wait_cyc(last_end + 3);
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL %s start_count got %0d exp %0d", name, log_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s start[%0d] got %h exp %h", name, i, log_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (busy_cnt - bbase != last_end - c0) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d exp %0d", name, busy_cnt - bbase, last_end - c0);
    end
    checks++;
    if ({overrun, timeout_err} !== 2'b00) begin
      errors++;
      $display("FAIL %s stickies got %b exp 00", name, {overrun, timeout_err});
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 6; n++)
      test_frame($urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                 $urandom_range(1, 3), "random_frame");
  endtask

  task automatic test_level_done();
    p_level = 1'b1;
    test_frame(0, 1, 1, 1, "level_done");
    p_level = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c0, base;
    c0 = next_strobe();
    wait_cyc(c0 - 1);
    p_lat = 1; b_lat = 1; c_lat = 1; speed = 2'd0; run = 1'b1;
    base = log_q.size();
    exp_q.delete();
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(enc(0, c0 + 1 + f * FRAME_CYC));
      exp_q.push_back(enc(1, c0 + 3 + f * FRAME_CYC));
      exp_q.push_back(enc(2, c0 + 5 + f * FRAME_CYC));
    end
    wait_cyc(c0 + FRAME_CYC + 8);
    run = 1'b0;
    wait_cyc(c0 + FRAME_CYC + 12);
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL back_to_back start_count got %0d exp %0d", log_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL back_to_back start[%0d] got %h exp %h", i, log_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back overrun got %b exp 0", overrun);
    end
  endtask

  task automatic test_run_drop();
    int c0, base;
    c0 = next_strobe();
    wait_cyc(c0 - 1);
    p_lat = 2; b_lat = 4; c_lat = 2;
    speed = 2'($urandom_range(0, 3));
    run = 1'b1;
    base = log_q.size();
    wait_cyc(c0 + 5);
    run = 1'b0;
    wait_cyc(c0 + 8);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL run_drop busy_in_ball got %b exp 1", busy);
    end
    wait_cyc(c0 + 9);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL run_drop busy_after got %b exp 0", busy);
    end
    wait_cyc(c0 + 20);
    checks++;
    if (log_q.size() - base != 2) begin
      errors++;
      $display("FAIL run_drop start_count got %0d exp 2", log_q.size() - base);
    end else begin
      checks++;
      if (log_q[base] !== enc(0, c0 + 1) || log_q[base + 1] !== enc(1, c0 + 4)) begin
        errors++;
        $display("FAIL run_drop starts got %h,%h exp %h,%h", log_q[base], log_q[base + 1],
                 enc(0, c0 + 1), enc(1, c0 + 4));
      end
    end
  endtask

  task automatic test_timeout();
    int c0, s, base;
    c0 = next_strobe();
    wait_cyc(c0 - 1);
    p_lat = 2; b_lat = 25; c_lat = 2; speed = 2'd0; run = 1'b1;
    base = log_q.size();
    s = c0 + 4;
    wait_cyc(s + 19);
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_before got err/busy %b exp 01", {timeout_err, busy});
    end
    clr_err = 1'b1;
    wait_cyc(s + 20);
    clr_err = 1'b0;
    run = 1'b0;
    checks++;
    if ({timeout_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_set_wins got err/busy %b exp 10", {timeout_err, busy});
    end
    wait_cyc(s + 30);
    checks++;
    if (log_q.size() - base != 2) begin
      errors++;
      $display("FAIL timeout_late_done start_count got %0d exp 2", log_q.size() - base);
    end else begin
      checks++;
      if (log_q[base] !== enc(0, c0 + 1) || log_q[base + 1] !== enc(1, s)) begin
        errors++;
        $display("FAIL timeout_starts got %h,%h exp %h,%h", log_q[base], log_q[base + 1],
                 enc(0, c0 + 1), enc(1, s));
      end
    end
    checks++;
    if ({timeout_err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_sticky got err/busy %b exp 10", {timeout_err, busy});
    end
    clr_err = 1'b1;
    wait_cyc(s + 31);
    clr_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b exp 0", timeout_err);
    end
    b_lat = 2;
  endtask

  task automatic test_overrun();
    int c0, base;
    c0 = next_strobe();
    wait_cyc(c0 - 1);
    p_lat = 18; b_lat = 18; c_lat = 18; speed = 2'd0; run = 1'b1;
    base = log_q.size();
    wait_cyc(c0 + 40);
    checks++;
    if ({overrun, busy} !== 2'b01) begin
      errors++;
      $display("FAIL overrun_before got ovr/busy %b exp 01", {overrun, busy});
    end
    wait_cyc(c0 + 41);
    run = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got %b exp 1", overrun);
    end
    wait_cyc(c0 + 57);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_busy_coll got %b exp 1", busy);
    end
    wait_cyc(c0 + 58);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_busy_end got %b exp 0", busy);
    end
    wait_cyc(c0 + 60);
    checks++;
    if (log_q.size() - base != 3) begin
      errors++;
      $display("FAIL overrun_no_relaunch start_count got %0d exp 3", log_q.size() - base);
    end else begin
      checks++;
      if (log_q[base] !== enc(0, c0 + 1) || log_q[base + 1] !== enc(1, c0 + 20) ||
          log_q[base + 2] !== enc(2, c0 + 39)) begin
        errors++;
        $display("FAIL overrun_starts got %h,%h,%h exp %h,%h,%h", log_q[base], log_q[base + 1],
                 log_q[base + 2], enc(0, c0 + 1), enc(1, c0 + 20), enc(2, c0 + 39));
      end
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun_no_timeout got %b exp 0", timeout_err);
    end
    clr_err = 1'b1;
    wait_cyc(c0 + 61);
    clr_err = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %b exp 0", overrun);
    end
    p_lat = 2; b_lat = 2; c_lat = 2;
  endtask

`ifdef SCHED_SINGLE_STEP_EN
  task automatic test_step();
    int x, base, bbase;
    x = next_strobe() + 2;
    wait_cyc(x);
    p_lat = 1; b_lat = 1; c_lat = 1; speed = 2'd0;
    base = log_q.size();
    bbase = busy_cnt;
    step = 1'b1;
    wait_cyc(x + 1);
    step = 1'b0;
    wait_cyc(x + 8);
    run = 1'b1;
    step = 1'b1;
    wait_cyc(x + 9);
    step = 1'b0;
    wait_cyc(x + 11);
    run = 1'b0;
    wait_cyc(x + 14);
    checks++;
    if (log_q.size() - base != 3) begin
      errors++;
      $display("FAIL step start_count got %0d exp 3", log_q.size() - base);
    end else begin
      checks++;
      if (log_q[base] !== enc(0, x + 1) || log_q[base + 1] !== enc(1, x + 3) ||
          log_q[base + 2] !== enc(2, x + 5)) begin
        errors++;
        $display("FAIL step_starts got %h,%h,%h exp %h,%h,%h", log_q[base], log_q[base + 1],
                 log_q[base + 2], enc(0, x + 1), enc(1, x + 3), enc(2, x + 5));
      end
    end
    checks++;
    if (busy_cnt - bbase != 6) begin
      errors++;
      $display("FAIL step busy_cycles got %0d exp 6", busy_cnt - bbase);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int c0, base, bbase;
    c0 = next_strobe();
    wait_cyc(c0 - 1);
    p_lat = 2; b_lat = 2; c_lat = 2; speed = 2'd0; run = 1'b1;
    wait_cyc(c0 + 5);
    rst = 1'b1;
    #1;
    checks++;
    if ({tick, frame_strobe, paddle_start, ball_start, coll_start, busy, overrun, timeout_err, state_dbg} !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid outputs got %b exp 0",
        {tick, frame_strobe, paddle_start, ball_start, coll_start, busy, overrun, timeout_err, state_dbg});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    base = log_q.size();
    bbase = busy_cnt;
    exp_q.delete();
    exp_q.push_back(enc(0, 40));
    exp_q.push_back(enc(1, 43));
    exp_q.push_back(enc(2, 46));
    wait_cyc(49);
    run = 1'b0;
    wait_cyc(52);
    checks++;
    if (log_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid start_count got %0d exp %0d", log_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (log_q[base + i] !== exp_q[i]) begin
          errors++;
          $display("FAIL reset_mid start[%0d] got %h exp %h", i, log_q[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (busy_cnt - bbase != 9) begin
      errors++;
      $display("FAIL reset_mid busy_cycles got %0d exp 9", busy_cnt - bbase);
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_frame(0, 2, 2, 2, "speed0");
    test_frame(3, 1, 2, 3, "speed3");
    test_random_frames();
    test_level_done();
    test_back_to_back();
    test_run_drop();
    test_timeout();
    test_overrun();
`ifdef SCHED_SINGLE_STEP_EN
    test_step();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
